// File: rtl/mem_bus_arbiter.sv
// Shares one main-memory port between the I-cache and D-cache refill paths.
// D has fixed priority; a run counter forces an I grant after MAX_D_RUN
// consecutive D grants taken while I was waiting. One transaction in flight.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W    = 28,
  parameter int unsigned LINE_W    = 128,
  parameter int unsigned MAX_D_RUN = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_read,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [LINE_W-1:0] ic_rdata,
  output logic              ic_ready,
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              dc_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt
);

  localparam int unsigned RunW = $clog2(MAX_D_RUN + 1);
  localparam logic [RunW-1:0] RunMax = RunW'(MAX_D_RUN);

  typedef enum logic [1:0] {StIdle, StGrantI, StGrantD, StRelease} state_e;

  state_e              state_q;
  logic [RunW-1:0]     d_run_q;
  logic                mem_read_q;
  logic                mem_write_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [LINE_W-1:0]   mem_wdata_q;
  logic [CNT_W-1:0]    i_cnt_q;
  logic [CNT_W-1:0]    d_cnt_q;

  logic d_req;
  logic force_i;

  assign d_req   = dc_read | dc_write;
  // I has waited through a full run of D grants: it wins this arbitration.
  assign force_i = ic_read && (d_run_q == RunMax);

  // Arbitration FSM with registered memory strobes, run tracking and grant counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      d_run_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_cnt_q     <= '0;
      d_cnt_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (d_req && !force_i) begin
            state_q     <= StGrantD;
            mem_addr_q  <= dc_addr;
            // Write wins when both are raised; the D-cache re-requests the read.
            mem_write_q <= dc_write;
            mem_read_q  <= ~dc_write;
            mem_wdata_q <= dc_write ? dc_wdata : '0;
            if (!ic_read) begin
              d_run_q <= '0;
            end else if (d_run_q != RunMax) begin
              d_run_q <= d_run_q + RunW'(1);
            end
            if (d_cnt_q != '1) d_cnt_q <= d_cnt_q + CNT_W'(1);
          end else if (ic_read) begin
            state_q     <= StGrantI;
            mem_addr_q  <= ic_addr;
            mem_read_q  <= 1'b1;
            mem_write_q <= 1'b0;
            mem_wdata_q <= '0;
            d_run_q     <= '0;
            if (i_cnt_q != '1) i_cnt_q <= i_cnt_q + CNT_W'(1);
          end
        end
        StGrantI, StGrantD: begin
          // Strobes stay up until memory answers, even if the request is dropped.
          if (mem_ready) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            state_q     <= StRelease;
          end
        end
        StRelease: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Completion is forwarded combinationally to the current owner only
  always_comb begin
    ic_ready = (state_q == StGrantI) && mem_ready;
    dc_ready = (state_q == StGrantD) && mem_ready;
    ic_rdata = ic_ready ? mem_rdata : '0;
    dc_rdata = dc_ready ? mem_rdata : '0;
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign i_grant_cnt = i_cnt_q;
  assign d_grant_cnt = d_cnt_q;

endmodule
